// File: rtl/result_line_formatter_pkg.sv
// Shared constants, FSM encoding and ASCII helpers for the result line formatter.
package result_line_formatter_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam int         LINE_CHARS  = 16;
    localparam int         BCD_DIGITS  = 10;
    localparam int         LINE_W      = 8 * LINE_CHARS;
    localparam int         BCD_W       = 4 * BCD_DIGITS;

    localparam logic [LINE_W-1:0] BLANK_LINE = {LINE_CHARS{ASCII_SPACE}};
    localparam logic [95:0]       PASS_PFX   = "PASS, Error=";
    localparam logic [95:0]       FAIL_PFX   = "FAIL, Error=";

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV_ERR,
        ST_CONV_CYC,
        ST_PACK,
        ST_DONE
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/result_line_formatter_dabble_core.sv
// Iterative double-dabble: one add-3/shift step per enabled cycle, MSB first.
// clr together with shift_en restarts the conversion with bit_in as its first bit.
module dabble_core
    import result_line_formatter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [BCD_W-1:0] bcd
);

    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bcd <= '0;
        else if (clr && shift_en)
            bcd <= {{(BCD_W-1){1'b0}}, bit_in};
        else if (clr)
            bcd <= '0;
        else if (shift_en)
            bcd <= {adj[BCD_W-2:0], bit_in};
    end

endmodule

// File: rtl/result_line_formatter.sv
// Captures a PASS/FAIL result, converts error and cycle counts to decimal
// through one shared dabble engine, and packs two 16-char LCD lines.
module result_line_formatter
    import result_line_formatter_pkg::*;
#(
    parameter int ERR_W = 11,
    parameter int CYC_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pass,
    input  logic [ERR_W-1:0]  num_errors,
    input  logic [CYC_W-1:0]  cycles,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [LINE_W-1:0] line1,
    output logic [LINE_W-1:0] line2
);

    localparam int               CNT_W    = $clog2(CYC_W + 1);
    localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(ERR_W - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CYC_W - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pass_q;
    logic [ERR_W-1:0] err_sh;
    logic [CYC_W-1:0] cyc_sh;
    logic [15:0]      err_bcd;
    logic             err_sat;

    logic             accept;
    logic             clr;
    logic             shift_en;
    logic             bit_in;
    logic [BCD_W-1:0] bcd;

    assign accept   = (state == ST_IDLE) && start;
    // Entering CONV_CYC restarts the engine; the error result is saved on that same edge.
    assign clr      = accept || (state == ST_CONV_CYC && cnt == '0);
    assign shift_en = (state == ST_CONV_ERR) || (state == ST_CONV_CYC);
    assign bit_in   = (state == ST_CONV_ERR) ? err_sh[ERR_W-1] : cyc_sh[CYC_W-1];

    dabble_core u_dabble (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .bit_in   (bit_in),
        .bcd      (bcd)
    );

    logic [31:0]       err_field;
    logic [LINE_W-1:0] cyc_field;
    logic              err_lead;
    logic              cyc_lead;

    // Leading-zero blanking scans from the most significant digit; the units digit always shows.
    always_comb begin
        err_field = {4{ASCII_SPACE}};
        err_lead  = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (err_bcd[4*i +: 4] != 4'd0 || i == 0)
                err_lead = 1'b0;
            if (!err_lead)
                err_field[8*i +: 8] = digit_char(err_bcd[4*i +: 4]);
        end
        if (err_sat)
            err_field = {4{digit_char(4'd9)}};

        cyc_field = BLANK_LINE;
        cyc_lead  = 1'b1;
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*i +: 4] != 4'd0 || i == 0)
                cyc_lead = 1'b0;
            if (!cyc_lead)
                cyc_field[8*i +: 8] = digit_char(bcd[4*i +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pass_q  <= 1'b0;
            err_sh  <= '0;
            cyc_sh  <= '0;
            err_bcd <= '0;
            err_sat <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            valid   <= 1'b0;
            line1   <= BLANK_LINE;
            line2   <= BLANK_LINE;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pass_q <= pass;
                        err_sh <= num_errors;
                        cyc_sh <= cycles;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        valid  <= 1'b0;
                        state  <= ST_CONV_ERR;
                    end
                end
                ST_CONV_ERR: begin
                    err_sh <= err_sh << 1;
                    if (cnt == ERR_LAST) begin
                        cnt   <= '0;
                        state <= ST_CONV_CYC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CONV_CYC: begin
                    cyc_sh <= cyc_sh << 1;
                    if (cnt == '0) begin
                        err_bcd <= bcd[15:0];
                        err_sat <= |bcd[BCD_W-1:16];
                    end
                    if (cnt == CYC_LAST) begin
                        cnt   <= '0;
                        state <= ST_PACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PACK: begin
                    line1 <= {(pass_q ? PASS_PFX : FAIL_PFX), err_field};
                    line2 <= cyc_field;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_line_formatter.sv
// Randomized self-checking bench; expected lines come from $sformatf-based formatting.
module tb_result_line_formatter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, pass;
    logic [10:0]  num_errors;
    logic [31:0]  cycles;
    logic         busy, done, valid;
    logic [127:0] line1, line2;

    logic         start14, pass14;
    logic [13:0]  err14;
    logic [31:0]  cyc14;
    logic         busy14, done14, valid14;
    logic [127:0] l1_14, l2_14;

    int errors = 0;
    int checks = 0;

    localparam int LAT   = 45;
    localparam int LAT14 = 48;

    result_line_formatter dut (
        .clk(clk), .rst(rst), .start(start), .pass(pass),
        .num_errors(num_errors), .cycles(cycles),
        .busy(busy), .done(done), .valid(valid), .line1(line1), .line2(line2)
    );

    result_line_formatter #(.ERR_W(14), .CYC_W(32)) dut14 (
        .clk(clk), .rst(rst), .start(start14), .pass(pass14),
        .num_errors(err14), .cycles(cyc14),
        .busy(busy14), .done(done14), .valid(valid14), .line1(l1_14), .line2(l2_14)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] s2v(input string s);
        logic [127:0] v;
        for (int i = 0; i < 16; i++)
            v[127-8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
        return v;
    endfunction

    function automatic logic [127:0] exp_l1(input bit p, input int unsigned e);
        string f, pf, s;
        f  = (e > 9999) ? "9999" : $sformatf("%4d", e);
        pf = p ? "PASS" : "FAIL";
        s  = {pf, ", Error=", f};
        return s2v(s);
    endfunction

    function automatic logic [127:0] exp_l2(input int unsigned c);
        return s2v($sformatf("%16d", c));
    endfunction

    task automatic do_start(input bit p, input int unsigned e, input int unsigned c);
        @(negedge clk);
        start = 1'b1; pass = p; num_errors = 11'(e); cycles = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int lat);
        lat = k0;
        while (lat < 200) begin
            @(posedge clk); lat++; #1;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; pass = 1'b1; num_errors = 11'd5; cycles = 32'd7;
        start14 = 1'b0; pass14 = 1'b0; err14 = '0; cyc14 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid); end
        checks++; if (line1 !== s2v("")) begin errors++; $display("FAIL reset_line1: got \"%s\"", line1); end
        checks++; if (line2 !== s2v("")) begin errors++; $display("FAIL reset_line2: got \"%s\"", line2); end
        @(negedge clk); rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        do_start(1'b1, 0, 1234);
        checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL basic_accept: busy=%b valid=%b exp 1/0", busy, valid); end
        wait_done(0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency: got %0d exp %0d", lat, LAT); end
        checks++; if (line1 !== exp_l1(1'b1, 0)) begin errors++; $display("FAIL basic_line1: got \"%s\" exp \"%s\"", line1, exp_l1(1'b1, 0)); end
        checks++; if (line2 !== exp_l2(1234)) begin errors++; $display("FAIL basic_line2: got \"%s\" exp \"%s\"", line2, exp_l2(1234)); end
        checks++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_flags: valid=%b busy=%b exp 1/0", valid, busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL basic_pulse: done=%b valid=%b exp 0/1", done, valid); end
    endtask

    task automatic test_max();
        int lat;
        do_start(1'b0, 2047, 32'hFFFF_FFFF);
        wait_done(0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL max_latency: got %0d exp %0d", lat, LAT); end
        checks++; if (line1 !== exp_l1(1'b0, 2047)) begin errors++; $display("FAIL max_line1: got \"%s\" exp \"%s\"", line1, exp_l1(1'b0, 2047)); end
        checks++; if (line2 !== exp_l2(32'hFFFF_FFFF)) begin errors++; $display("FAIL max_line2: got \"%s\" exp \"%s\"", line2, exp_l2(32'hFFFF_FFFF)); end
    endtask

    task automatic test_random();
        int lat;
        bit p;
        int unsigned e, c;
        for (int n = 0; n < 8; n++) begin
            p = 1'($urandom_range(0, 1));
            e = $urandom_range(0, 2047);
            c = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 999);
            do_start(p, e, c);
            wait_done(0, lat);
            checks++; if (lat !== LAT) begin errors++; $display("FAIL rand%0d_latency: got %0d exp %0d", n, lat, LAT); end
            checks++; if (line1 !== exp_l1(p, e)) begin errors++; $display("FAIL rand%0d_line1: got \"%s\" exp \"%s\"", n, line1, exp_l1(p, e)); end
            checks++; if (line2 !== exp_l2(c)) begin errors++; $display("FAIL rand%0d_line2: got \"%s\" exp \"%s\"", n, line2, exp_l2(c)); end
        end
    endtask

    task automatic test_saturate();
        int lat;
        int unsigned ev [2] = '{12000, 16383};
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            start14 = 1'b1; pass14 = 1'b1; err14 = 14'(ev[n]); cyc14 = 32'd0;
            @(posedge clk); #1;
            start14 = 1'b0;
            lat = 0;
            while (lat < 200) begin
                @(posedge clk); lat++; #1;
                if (done14) break;
            end
            checks++; if (lat !== LAT14) begin errors++; $display("FAIL sat%0d_latency: got %0d exp %0d", n, lat, LAT14); end
            checks++; if (l1_14 !== exp_l1(1'b1, ev[n])) begin errors++; $display("FAIL sat%0d_line1: got \"%s\" exp \"%s\"", n, l1_14, exp_l1(1'b1, ev[n])); end
            checks++; if (l2_14 !== exp_l2(0)) begin errors++; $display("FAIL sat%0d_line2: got \"%s\" exp \"%s\"", n, l2_14, exp_l2(0)); end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        do_start(1'b1, 37, 555);
        num_errors = 11'd999; cycles = 32'd42; pass = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; pass = 1'b0; num_errors = 11'd1500; cycles = 32'd98765;
        @(posedge clk); #1;
        start = 1'b0; num_errors = 11'd3; cycles = 32'd1;
        wait_done(10, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL ignore_latency: got %0d exp %0d", lat, LAT); end
        checks++; if (line1 !== exp_l1(1'b1, 37)) begin errors++; $display("FAIL ignore_line1: got \"%s\" exp \"%s\"", line1, exp_l1(1'b1, 37)); end
        checks++; if (line2 !== exp_l2(555)) begin errors++; $display("FAIL ignore_line2: got \"%s\" exp \"%s\"", line2, exp_l2(555)); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL ignore_not_queued: busy=%b valid=%b exp 0/1", busy, valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_start(1'b0, 88, 7777);
        repeat (19) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_flags: busy=%b valid=%b done=%b exp 0/0/0", busy, valid, done); end
        checks++; if (line1 !== s2v("") || line2 !== s2v("")) begin errors++; $display("FAIL midrst_lines: got \"%s\" / \"%s\" exp blanks", line1, line2); end
        @(negedge clk); rst = 1'b0;
        do_start(1'b1, 9, 10);
        wait_done(0, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_latency: got %0d exp %0d", lat, LAT); end
        checks++; if (line1 !== exp_l1(1'b1, 9) || line2 !== exp_l2(10)) begin errors++; $display("FAIL midrst_lines_after: got \"%s\" / \"%s\"", line1, line2); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] old1, old2;
        old1 = exp_l1(1'b1, 9);
        old2 = exp_l2(10);
        start = 1'b1; pass = 1'b0; num_errors = 11'd1024; cycles = 32'd100000;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: valid=%b busy=%b exp 0/1", valid, busy); end
        repeat (43) @(posedge clk);
        #1;
        checks++; if (line1 !== old1 || line2 !== old2) begin errors++; $display("FAIL b2b_held: got \"%s\" / \"%s\" exp \"%s\" / \"%s\"", line1, line2, old1, old2); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_low: got %b exp 0", valid); end
        wait_done(43, lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency: got %0d exp %0d", lat, LAT); end
        checks++; if (line1 !== exp_l1(1'b0, 1024) || line2 !== exp_l2(100000)) begin errors++; $display("FAIL b2b_lines: got \"%s\" / \"%s\"", line1, line2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_random();
        test_saturate();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
